// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, memory geometry and
// small byte/word helpers reused by loader blocks.
package riscv_pkg;

    localparam int IMEM_ADDR_W = 7;
    localparam int IMEM_DEPTH  = 128;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_e;

    // Place byte b into little-endian lane 'lane' of word, leaving the other lanes intact.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = b;
            2'd1:    res[15:8]  = b;
            2'd2:    res[23:16] = b;
            2'd3:    res[31:24] = b;
            default: res        = word;
        endcase
        return res;
    endfunction

    // Running image checksum: plain XOR accumulation of data bytes.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-to-word assembler: collects four bytes little-endian and emits the finished word with
// a one-cycle word_valid pulse on the cycle after the fourth byte.
module word_assembler
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [31:0] r_out;
    logic        r_valid;
    logic [31:0] w_ins;

    assign w_ins      = insert_byte(r_word, r_cnt, byte_data);
    assign last_byte  = (r_cnt == 2'd3);
    assign word_valid = r_valid;
    assign word_data  = r_out;

    // Byte lane counter, partial word, and registered finished word with its valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 2'd0;
            r_word  <= 32'd0;
            r_out   <= 32'd0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_cnt   <= 2'd0;
            r_word  <= 32'd0;
            r_out   <= 32'd0;
            r_valid <= 1'b0;
        end else if (byte_valid) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= w_ins;
            if (r_cnt == 2'd3) begin
                r_out   <= w_ins;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed, XOR-checksummed byte stream, writes the
// image into imem from word 0 upward, and keeps the core held until a valid image is in place.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    // One extra index bit so a full-depth image ends without wrapping.
    localparam int IDX_W = ADDR_W + 1;

    loader_state_e     r_state;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_xor;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_ready;
    logic              r_done;
    logic              r_error;
    logic              r_hold;

    logic              w_xfer;
    logic              w_data_xfer;
    logic              w_clr;
    logic              w_last_byte;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [15:0]       w_len_in;
    logic [15:0]       w_idx_next;

    assign w_xfer      = rx_valid & r_ready;
    assign w_data_xfer = w_xfer & (r_state == DATA);
    assign w_clr       = start & ((r_state == DONE) | (r_state == ERROR));
    assign w_len_in    = {rx_data, r_len_lo};
    assign w_idx_next  = 16'(r_idx) + 16'd1;

    assign rx_ready   = r_ready;
    assign imem_we    = w_word_valid;
    assign imem_waddr = r_waddr;
    assign imem_wdata = w_word;
    assign core_hold  = r_hold;
    assign done       = r_done;
    assign error      = r_error;

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (reset),
        .clr        (w_clr),
        .byte_valid (w_data_xfer),
        .byte_data  (rx_data),
        .last_byte  (w_last_byte),
        .word_valid (w_word_valid),
        .word_data  (w_word)
    );

    // Loader FSM with length capture, word index, running checksum and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= LEN_LO;
            r_len_lo <= 8'd0;
            r_len    <= 16'd0;
            r_idx    <= '0;
            r_xor    <= 8'd0;
            r_waddr  <= '0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_hold   <= 1'b1;
        end else begin
            case (r_state)
                LEN_LO: begin
                    // Accepting state: ready comes up the cycle after reset release.
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        r_len_lo <= rx_data;
                        r_state  <= LEN_HI;
                    end else begin
                        r_state  <= LEN_LO;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len <= w_len_in;
                        if (w_len_in == 16'd0) begin
                            r_state <= CSUM;
                        end else if (w_len_in > 16'(DEPTH)) begin
                            // Oversized image: refuse before touching imem.
                            r_state <= ERROR;
                            r_error <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_state <= LEN_HI;
                    end
                end
                DATA: begin
                    if (w_xfer) begin
                        r_xor <= csum_update(r_xor, rx_data);
                        if (w_last_byte) begin
                            // The assembler pulses the write next cycle; pair it with this index.
                            r_waddr <= r_idx[ADDR_W-1:0];
                            r_idx   <= r_idx + IDX_W'(1);
                            if (w_idx_next == r_len) begin
                                r_state <= CSUM;
                            end else begin
                                r_state <= DATA;
                            end
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_state <= DATA;
                    end
                end
                CSUM: begin
                    if (w_xfer) begin
                        r_ready <= 1'b0;
                        if (rx_data == r_xor) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                            r_hold  <= 1'b1;
                        end
                    end else begin
                        r_state <= CSUM;
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        r_state  <= LEN_LO;
                        r_ready  <= 1'b1;
                        r_done   <= 1'b0;
                        r_error  <= 1'b0;
                        r_hold   <= 1'b1;
                        r_idx    <= '0;
                        r_xor    <= 8'd0;
                        r_len    <= 16'd0;
                        r_len_lo <= 8'd0;
                    end else begin
                        r_state  <= r_state;
                    end
                end
                default: begin
                    r_state <= LEN_LO;
                    r_ready <= 1'b0;
                    r_hold  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: reset, normal load, bad checksum, length
// limits, empty image with re-arm, and a stalled stream compared against a gap-free one.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [6:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0]  wr_alog [0:511];
    logic [31:0] wr_dlog [0:511];
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    // Record every imem write (address and data) in order of occurrence.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 512) begin
                wr_alog[wr_cnt] = imem_waddr;
                wr_dlog[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte from a negedge and hold it until it is accepted at a posedge.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            rx_data  = b;
            rx_valid = 1'b1;
            acc      = (rx_ready === 1'b1);
            @(posedge clk);
            n++;
        end
        if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_we"},    {31'd0, imem_we},  32'd0);
        chk({tag, "_waddr"}, {25'd0, imem_waddr}, 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_hold"},  {31'd0, core_hold}, 32'd1);
        chk({tag, "_done"},  {31'd0, done},  32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    function automatic logic [7:0] pat_byte(input int j);
        int v;
        v = j * 7 + 3;
        return v[7:0];
    endfunction

    // Send a 16-word patterned image, optionally with random idle cycles between bytes.
    task automatic send_image16(input bit gaps);
        logic [7:0] cs;
        cs = 8'd0;
        send_byte(8'h10);
        send_byte(8'h00);
        for (int j = 0; j < 64; j++) begin
            if (gaps && ($urandom_range(0, 9) < 3)) idle($urandom_range(1, 3));
            send_byte(pat_byte(j));
            cs = cs ^ pat_byte(j);
        end
        if (gaps) idle(2);
        send_byte(cs);
    endtask

    initial begin
        int base;
        int base_a;
        int base_b;
        logic [31:0] exp_w;

        // ---- Test 1: reset values, then reset in the middle of an image ----
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("t1_por");
        reset = 1'b1;
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h44332211);
        send_byte(8'h55);
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk_reset_vals("t1_mid");
        repeat (3) @(negedge clk);
        chk_reset_vals("t1_hold3");
        reset = 1'b1;

        // ---- Test 2: N=2 image, correct checksum (0x13^0x93^0x10 = 0x90) ----
        base = wr_cnt;
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h00000013);
        #2;
        chk("t2_we_latency", {31'd0, imem_we}, 32'd1);
        chk("t2_waddr0", {25'd0, imem_waddr}, 32'd0);
        chk("t2_wdata0", imem_wdata, 32'h00000013);
        send_word(32'h00100093);
        send_byte(8'h90);
        #2;
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_hold", {31'd0, core_hold}, 32'd0);
        chk("t2_error", {31'd0, error}, 32'd0);
        chk("t2_ready", {31'd0, rx_ready}, 32'd0);
        idle(2);
        chk("t2_wcount", wr_cnt - base, 32'd2);
        chk("t2_a0", {25'd0, wr_alog[base]}, 32'd0);
        chk("t2_d0", wr_dlog[base], 32'h00000013);
        chk("t2_a1", {25'd0, wr_alog[base+1]}, 32'd1);
        chk("t2_d1", wr_dlog[base+1], 32'h00100093);

        // ---- Test 3: N=1, 0xDEADBEEF, wrong checksum (correct would be 0x22) ----
        pulse_start();
        base = wr_cnt;
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hDEADBEEF);
        send_byte(8'h00);
        #2;
        chk("t3_error", {31'd0, error}, 32'd1);
        chk("t3_done", {31'd0, done}, 32'd0);
        chk("t3_ready", {31'd0, rx_ready}, 32'd0);
        chk("t3_hold", {31'd0, core_hold}, 32'd1);
        idle(2);
        chk("t3_wcount", wr_cnt - base, 32'd1);
        chk("t3_a0", {25'd0, wr_alog[base]}, 32'd0);
        chk("t3_d0", wr_dlog[base], 32'hDEADBEEF);

        // ---- Test 4a: N=129 rejected right after the length ----
        pulse_start();
        base = wr_cnt;
        send_byte(8'h81);
        send_byte(8'h00);
        #2;
        chk("t4a_error", {31'd0, error}, 32'd1);
        chk("t4a_ready", {31'd0, rx_ready}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            chk("t4a_no_ready", {31'd0, rx_ready}, 32'd0);
        end
        idle(2);
        chk("t4a_wcount", wr_cnt - base, 32'd0);
        chk("t4a_hold", {31'd0, core_hold}, 32'd1);

        // ---- Test 4b: N=128, byte j = j mod 256, checksum 0x00 ----
        pulse_start();
        base = wr_cnt;
        send_byte(8'h80);
        send_byte(8'h00);
        for (int j = 0; j < 512; j++) begin
            send_byte(8'(j));
        end
        send_byte(8'h00);
        #2;
        chk("t4b_done", {31'd0, done}, 32'd1);
        chk("t4b_error", {31'd0, error}, 32'd0);
        idle(2);
        chk("t4b_wcount", wr_cnt - base, 32'd128);
        chk("t4b_first_a", {25'd0, wr_alog[base]}, 32'd0);
        chk("t4b_first_d", wr_dlog[base], 32'h03020100);
        chk("t4b_last_a", {25'd0, wr_alog[base+127]}, 32'd127);
        chk("t4b_last_d", wr_dlog[base+127], 32'hFFFEFDFC);

        // ---- Test 5: empty image, then re-arm with start ----
        pulse_start();
        base = wr_cnt;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        #2;
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_hold", {31'd0, core_hold}, 32'd0);
        idle(2);
        chk("t5_wcount", wr_cnt - base, 32'd0);
        pulse_start();
        chk("t5_rearm_done", {31'd0, done}, 32'd0);
        chk("t5_rearm_hold", {31'd0, core_hold}, 32'd1);
        chk("t5_rearm_ready", {31'd0, rx_ready}, 32'd1);

        // ---- Test 6: 16-word image without and with idle gaps ----
        base_a = wr_cnt;
        send_image16(1'b0);
        #2;
        chk("t6a_done", {31'd0, done}, 32'd1);
        idle(2);
        chk("t6a_wcount", wr_cnt - base_a, 32'd16);
        pulse_start();
        base_b = wr_cnt;
        send_image16(1'b1);
        #2;
        chk("t6b_done", {31'd0, done}, 32'd1);
        idle(2);
        chk("t6b_wcount", wr_cnt - base_b, 32'd16);
        for (int i = 0; i < 16; i++) begin
            exp_w = {pat_byte(4*i+3), pat_byte(4*i+2), pat_byte(4*i+1), pat_byte(4*i)};
            chk("t6a_addr", {25'd0, wr_alog[base_a+i]}, 32'(i));
            chk("t6a_data", wr_dlog[base_a+i], exp_w);
            chk("t6b_addr", {25'd0, wr_alog[base_b+i]}, 32'(i));
            chk("t6b_data", wr_dlog[base_b+i], exp_w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
